sprite_plot_scheduler: RTL and testbench
========================================

Name: sprite_plot_scheduler

Overview:
- Shares the single VGA pixel-plot port (x, y, colour, plot) among NUM_SPRITES sprite drawers (birds, hunter).
- On each frame tick, walks the enabled slots in index order. For each slot it erases the sprite at its old position, pulses the slot's position update, then redraws it.
- Sits between the frame_counter tick, the per-sprite drawer/position blocks, and vga_adapter.

Parameters:
- NUM_SPRITES, 7, number of drawer slots (slot NUM_SPRITES-1 = hunter by convention)
- X_W, 8, pixel x width (160-wide screen)
- Y_W, 7, pixel y width (120-high screen)
- COLOUR_W, 3, colour width
- ERASE_COLOUR, 3'b000, background colour used for erase passes
- TIMEOUT, 63, maximum WAIT cycles per pass before the pass is aborted

Ports:
- clock  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, from frame_counter
- slot_en  in  NUM_SPRITES  per-slot enable (from SW-derived bird count)
- slot_colour  in  NUM_SPRITES*COLOUR_W  draw colour per slot, packed with slot i at [i*COLOUR_W +: COLOUR_W]
- spr_start  out  NUM_SPRITES  one-cycle pulse to the granted drawer, restarting its pixel walk
- spr_erase  out  1  high during erase passes; drawer emits its old position
- spr_advance  out  NUM_SPRITES  one-cycle pulse to the slot's position counter, between erase and draw
- spr_x  in  NUM_SPRITES*X_W  drawer pixel x, packed
- spr_y  in  NUM_SPRITES*Y_W  drawer pixel y, packed
- spr_valid  in  NUM_SPRITES  drawer pixel valid this cycle
- spr_done  in  NUM_SPRITES  drawer level, high when its walk is finished
- vga_x  out  X_W  registered plot x
- vga_y  out  Y_W  registered plot y
- vga_colour  out  COLOUR_W  registered plot colour
- vga_plot  out  1  registered plot strobe
- busy  out  1  high while not in IDLE
- frame_done  out  1  one-cycle pulse when a frame's pass list completes
- overrun  out  1  sticky; set when a frame_tick arrives while busy with pending already set; cleared only by reset
- timeout_err  out  1  sticky; set when any pass times out; cleared only by reset

Behaviour:
- Reset (asynchronous):
  - state = IDLE; slot index = 0; pending = 0; latched enables = 0.
  - All outputs = 0.
- FSM states: IDLE, SELECT, ERASE_START, ERASE_WAIT, ADVANCE, DRAW_START, DRAW_WAIT, FRAME_END.
- IDLE:
  - On frame_tick or pending: latch slot_en into en_q, set idx = 0, clear pending, go to SELECT.
- SELECT:
  - If idx == NUM_SPRITES, go to FRAME_END.
  - Else if en_q[idx] == 1, go to ERASE_START.
  - Else idx++ and stay in SELECT (one cycle per skipped slot).
- ERASE_START:
  - spr_start[idx] = 1, spr_erase = 1, wait counter = 0, go to ERASE_WAIT.
- ERASE_WAIT (spr_erase held at 1):
  - Forward granted pixels. When spr_valid[idx], next cycle vga_plot = 1, vga_x/vga_y = granted pixel, vga_colour = ERASE_COLOUR.
  - spr_done[idx] is ignored in the first WAIT cycle, which covers the drawer's stale done.
  - From the second cycle on, spr_done[idx] = 1 -> ADVANCE.
  - If the counter reaches TIMEOUT -> set timeout_err and go to ADVANCE.
- ADVANCE:
  - spr_advance[idx] = 1 for one cycle, go to DRAW_START.
- DRAW_START / DRAW_WAIT:
  - Same as the erase pass, with spr_erase = 0 and colour = slot_colour[idx].
  - On done or timeout: idx++ and go to SELECT.
- FRAME_END:
  - frame_done = 1 for one cycle, go to IDLE.
- Plot latency:
  - Exactly 1 cycle from spr_valid to vga_plot.
  - vga_plot = 0 in every cycle where the granted slot has no valid pixel, and in every non-WAIT state.
- Grant isolation: spr_valid, spr_x, spr_y and spr_done from non-granted slots never reach the VGA outputs.
- frame_tick while busy:
  - First tick sets pending; the new frame then starts in the cycle after FRAME_END's IDLE.
  - A further tick while pending = 1 sets overrun.
- slot_en changes mid-frame are ignored until the next frame latch.
- A frame with en_q == 0 takes NUM_SPRITES + 2 cycles from tick to frame_done (1 IDLE + NUM_SPRITES SELECT skips + 1 FRAME_END) and produces no plots.
- idx width = clog2(NUM_SPRITES + 1). There is no wrap; idx stops at NUM_SPRITES.
- Reset mid-pass aborts immediately; no further start or advance pulse is issued.

Decomposition:
- Shared package duck_hunt_pkg: state encoding localparams; X_W, Y_W, COLOUR_W; ERASE_COLOUR.
- One natural sub-module: plot_mux. It performs the indexed selection of x, y, valid and done from the packed buses plus the output register stage.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: assert reset mid-DRAW_WAIT on slot 2 -> all outputs 0 asynchronously; no spr_start pulse until the next frame_tick.
- Single slot: slot_en = 7'b0000001, drawer model emitting 13 valid pixels around (5,20), slot_colour = 3'b111 -> 13 plots with colour 000, then one spr_advance[0] pulse, then 13 plots with colour 111 at the new position, then frame_done.
- Skip: slot_en = 7'b1000100 -> passes for slots 2 and 6 only; spr_start is never pulsed for other slots. With slot_en = 0 -> frame_done exactly 9 cycles after the tick and zero plots.
- Isolation: drive spr_valid from slot 3 continuously while slot 1 is granted -> vga_plot only carries slot 1's pixels.
- Overrun: two frame_ticks during one busy frame -> the first sets pending and a second frame runs back-to-back; the second tick sets overrun, which stays high.
- Timeout: drawer never asserts done -> after 63 WAIT cycles timeout_err = 1 and the scheduler proceeds to ADVANCE and then the draw pass.

Source files
------------

// File: rtl/sprite_plot_scheduler_pkg.sv
// Shared widths, colours and state encoding for the sprite plot scheduler.
// Screen is 160x120 with 3-bit colour.
package sprite_plot_scheduler_pkg;
    localparam int NUM_SPRITES = 7;
    localparam int X_W         = 8;
    localparam int Y_W         = 7;
    localparam int COLOUR_W    = 3;
    localparam int TIMEOUT     = 63;
    localparam int IDX_W       = $clog2(NUM_SPRITES + 1);
    localparam int CNT_W       = $clog2(TIMEOUT + 1);

    localparam logic [COLOUR_W-1:0] ERASE_COLOUR = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ERASE_START,
        S_ERASE_WAIT,
        S_ADVANCE,
        S_DRAW_START,
        S_DRAW_WAIT,
        S_FRAME_END
    } state_t;
endpackage

// File: rtl/sprite_plot_scheduler_if.sv
// Bundle between the scheduler, the sprite drawers and the VGA adapter.
// master = scheduler side, slave = drawers / frame counter / adapter side.
interface sprite_plot_scheduler_if;
    import sprite_plot_scheduler_pkg::*;

    logic                            frame_tick;
    logic [NUM_SPRITES-1:0]          slot_en;
    logic [NUM_SPRITES*COLOUR_W-1:0] slot_colour;
    logic [NUM_SPRITES-1:0]          spr_start;
    logic                            spr_erase;
    logic [NUM_SPRITES-1:0]          spr_advance;
    logic [NUM_SPRITES*X_W-1:0]      spr_x;
    logic [NUM_SPRITES*Y_W-1:0]      spr_y;
    logic [NUM_SPRITES-1:0]          spr_valid;
    logic [NUM_SPRITES-1:0]          spr_done;
    logic [X_W-1:0]                  vga_x;
    logic [Y_W-1:0]                  vga_y;
    logic [COLOUR_W-1:0]             vga_colour;
    logic                            vga_plot;
    logic                            busy;
    logic                            frame_done;
    logic                            overrun;
    logic                            timeout_err;

    modport master (
        input  frame_tick, slot_en, slot_colour,
        input  spr_x, spr_y, spr_valid, spr_done,
        output spr_start, spr_erase, spr_advance,
        output vga_x, vga_y, vga_colour, vga_plot,
        output busy, frame_done, overrun, timeout_err
    );

    modport slave (
        output frame_tick, slot_en, slot_colour,
        output spr_x, spr_y, spr_valid, spr_done,
        input  spr_start, spr_erase, spr_advance,
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  busy, frame_done, overrun, timeout_err
    );
endinterface

// File: rtl/sprite_plot_scheduler_plot_mux.sv
// Selects the granted drawer's pixel/done from the packed buses and
// registers the plot port, so only the granted slot can ever reach VGA.
module sprite_plot_scheduler_plot_mux
    import sprite_plot_scheduler_pkg::*;
(
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [IDX_W-1:0]                i_sel,
    input  logic                            i_active,
    input  logic [COLOUR_W-1:0]             i_colour,
    input  logic [NUM_SPRITES*X_W-1:0]      i_x,
    input  logic [NUM_SPRITES*Y_W-1:0]      i_y,
    input  logic [NUM_SPRITES-1:0]          i_valid,
    input  logic [NUM_SPRITES-1:0]          i_done,
    output logic                            o_done,
    output logic [X_W-1:0]                  o_x,
    output logic [Y_W-1:0]                  o_y,
    output logic [COLOUR_W-1:0]             o_colour,
    output logic                            o_plot
);
    logic           w_hit;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic           r_plot;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [COLOUR_W-1:0] r_colour;

    assign w_hit  = i_active && i_valid[i_sel];
    assign w_x    = i_x[i_sel*X_W +: X_W];
    assign w_y    = i_y[i_sel*Y_W +: Y_W];
    assign o_done = i_done[i_sel];

    // One-cycle plot register; coordinates hold between plots.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
        end else begin
            r_plot <= w_hit;
            if (w_hit) begin
                r_x      <= w_x;
                r_y      <= w_y;
                r_colour <= i_colour;
            end
        end
    end

    assign o_plot   = r_plot;
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_colour = r_colour;
endmodule

// File: rtl/sprite_plot_scheduler.sv
// Per-frame erase/advance/redraw sequencer sharing one VGA plot port
// among the sprite drawers; slots are visited in index order.
module sprite_plot_scheduler
    import sprite_plot_scheduler_pkg::*;
(
    input  logic clock,
    input  logic reset,
    sprite_plot_scheduler_if.master bus
);
    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pending;
    logic [NUM_SPRITES-1:0] r_en_q;
    logic [NUM_SPRITES-1:0] r_start;
    logic [NUM_SPRITES-1:0] r_advance;
    logic                   r_erase;
    logic                   r_busy;
    logic                   r_frame_done;
    logic                   r_overrun;
    logic                   r_timeout;

    logic [IDX_W-1:0]    w_sel;
    logic                w_wait;
    logic                w_done;
    logic                w_expired;
    logic                w_pass_end;
    logic [COLOUR_W-1:0] w_colour;
    logic [X_W-1:0]      w_vga_x;
    logic [Y_W-1:0]      w_vga_y;
    logic [COLOUR_W-1:0] w_vga_colour;
    logic                w_vga_plot;

    // idx parks at NUM_SPRITES at frame end; keep selects in range.
    assign w_sel      = (r_idx < IDX_W'(NUM_SPRITES)) ? r_idx : '0;
    assign w_wait     = (r_state == S_ERASE_WAIT) || (r_state == S_DRAW_WAIT);
    assign w_colour   = r_erase ? ERASE_COLOUR
                                : bus.slot_colour[w_sel*COLOUR_W +: COLOUR_W];
    assign w_expired  = (r_cnt == CNT_W'(TIMEOUT - 1));
    // First WAIT cycle sees the drawer's stale done from its last walk.
    assign w_pass_end = ((r_cnt != '0) && w_done) || w_expired;

    sprite_plot_scheduler_plot_mux u_plot_mux (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_sel    (w_sel),
        .i_active (w_wait),
        .i_colour (w_colour),
        .i_x      (bus.spr_x),
        .i_y      (bus.spr_y),
        .i_valid  (bus.spr_valid),
        .i_done   (bus.spr_done),
        .o_done   (w_done),
        .o_x      (w_vga_x),
        .o_y      (w_vga_y),
        .o_colour (w_vga_colour),
        .o_plot   (w_vga_plot)
    );

    // Sequencer with registered start/advance/frame pulses and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_en_q       <= '0;
            r_start      <= '0;
            r_advance    <= '0;
            r_erase      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_start      <= '0;
            r_advance    <= '0;
            r_frame_done <= 1'b0;
            if (r_state != S_IDLE && bus.frame_tick) begin
                if (r_pending) r_overrun <= 1'b1;
                else           r_pending <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (bus.frame_tick || r_pending) begin
                        r_en_q    <= bus.slot_en;
                        r_idx     <= '0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (r_idx == IDX_W'(NUM_SPRITES)) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_FRAME_END;
                    end else if (r_en_q[w_sel]) begin
                        r_start[w_sel] <= 1'b1;
                        r_erase        <= 1'b1;
                        r_state        <= S_ERASE_START;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_ERASE_START: begin
                    r_cnt   <= '0;
                    r_state <= S_ERASE_WAIT;
                end
                S_ERASE_WAIT: begin
                    if (w_pass_end) begin
                        if (w_expired) r_timeout <= 1'b1;
                        r_advance[w_sel] <= 1'b1;
                        r_erase          <= 1'b0;
                        r_state          <= S_ADVANCE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ADVANCE: begin
                    r_start[w_sel] <= 1'b1;
                    r_state        <= S_DRAW_START;
                end
                S_DRAW_START: begin
                    r_cnt   <= '0;
                    r_state <= S_DRAW_WAIT;
                end
                S_DRAW_WAIT: begin
                    if (w_pass_end) begin
                        if (w_expired) r_timeout <= 1'b1;
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_SELECT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FRAME_END: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.spr_start   = r_start;
    assign bus.spr_erase   = r_erase;
    assign bus.spr_advance = r_advance;
    assign bus.vga_x       = w_vga_x;
    assign bus.vga_y       = w_vga_y;
    assign bus.vga_colour  = w_vga_colour;
    assign bus.vga_plot    = w_vga_plot;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout;
endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Scoreboard bench for sprite_plot_scheduler with behavioural drawers.
// Drawers push expected plots when they emit; the VGA monitor pops them.
module tb_sprite_plot_scheduler;
    import sprite_plot_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sprite_plot_scheduler_if bus();

    sprite_plot_scheduler dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_plot   = 0;
    int n_fd     = 0;
    int n_start[NUM_SPRITES];
    int n_adv[NUM_SPRITES];

    logic [X_W+Y_W+COLOUR_W-1:0] sb[$];

    int                  npix[NUM_SPRITES];
    int                  k[NUM_SPRITES];
    bit                  act[NUM_SPRITES];
    bit                  hang[NUM_SPRITES];
    bit                  rogue[NUM_SPRITES];
    logic [X_W-1:0]      px[NUM_SPRITES];
    logic [Y_W-1:0]      py[NUM_SPRITES];
    logic [X_W-1:0]      mx[NUM_SPRITES];
    logic [Y_W-1:0]      my[NUM_SPRITES];
    logic                mv[NUM_SPRITES];
    logic                md[NUM_SPRITES];
    logic [COLOUR_W-1:0] mcol[NUM_SPRITES];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drawer models: stale done for one WAIT cycle, then a pixel walk.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (rst) begin
                act[i] = 1'b0;
                mv[i]  = 1'b0;
                md[i]  = 1'b1;
            end else if (bus.spr_start[i]) begin
                act[i]  = 1'b1;
                k[i]    = -1;
                mv[i]   = 1'b0;
                mcol[i] = bus.spr_erase ? ERASE_COLOUR
                                        : bus.slot_colour[i*COLOUR_W +: COLOUR_W];
            end else if (act[i]) begin
                if (k[i] < 0) begin
                    k[i]  = 0;
                    mv[i] = 1'b0;
                end else if (k[i] < npix[i]) begin
                    mx[i] = px[i] + X_W'(k[i] % 5);
                    my[i] = py[i] + Y_W'(k[i] / 5);
                    mv[i] = 1'b1;
                    md[i] = 1'b0;
                    sb.push_back({mx[i], my[i], mcol[i]});
                    k[i]++;
                end else begin
                    mv[i] = 1'b0;
                    if (!hang[i]) begin
                        md[i]  = 1'b1;
                        act[i] = 1'b0;
                    end
                end
            end else begin
                mv[i] = 1'b0;
            end
            if (!rst && bus.spr_advance[i]) begin
                px[i] = px[i] + 8'd4;
                py[i] = py[i] + 7'd1;
            end
            if (rogue[i]) begin
                mv[i] = 1'b1;
                md[i] = 1'b1;
                mx[i] = 8'hEE;
                my[i] = 7'h55;
            end
            bus.spr_x[i*X_W +: X_W] = mx[i];
            bus.spr_y[i*Y_W +: Y_W] = my[i];
            bus.spr_valid[i]        = mv[i];
            bus.spr_done[i]         = md[i];
        end
    end

    // VGA-side monitor: pops the scoreboard and counts pulses.
    always @(posedge clk) begin
        #1;
        if (bus.vga_plot) begin
            n_plot++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL plot_unexpected: got %0h expected no plot",
                         {bus.vga_x, bus.vga_y, bus.vga_colour});
            end else begin
                check("plot", {bus.vga_x, bus.vga_y, bus.vga_colour},
                      sb.pop_front());
            end
        end
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (bus.spr_start[i])   n_start[i]++;
            if (bus.spr_advance[i]) n_adv[i]++;
        end
        if (bus.frame_done) n_fd++;
    end

    task automatic clear_counts();
        n_plot = 0;
        n_fd   = 0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            n_start[i] = 0;
            n_adv[i]   = 0;
        end
    endtask

    function automatic logic [NUM_SPRITES-1:0] start_mask();
        logic [NUM_SPRITES-1:0] m = '0;
        for (int i = 0; i < NUM_SPRITES; i++) m[i] = (n_start[i] != 0);
        return m;
    endfunction

    function automatic logic [NUM_SPRITES-1:0] adv_mask();
        logic [NUM_SPRITES-1:0] m = '0;
        for (int i = 0; i < NUM_SPRITES; i++) m[i] = (n_adv[i] != 0);
        return m;
    endfunction

    function automatic logic [63:0] all_outs();
        return {bus.spr_start, bus.spr_erase, bus.spr_advance,
                bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot,
                bus.busy, bus.frame_done, bus.overrun, bus.timeout_err};
    endfunction

    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic wait_fd(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && n_fd < n; c++) @(negedge clk);
        check(tag, n_fd, n);
    endtask

    initial begin
        int n;
        bus.frame_tick  = 1'b0;
        bus.slot_en     = '0;
        bus.slot_colour = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            npix[i]  = 13;
            hang[i]  = 1'b0;
            rogue[i] = 1'b0;
            act[i]   = 1'b0;
            k[i]     = 0;
            px[i]    = X_W'(5 + 20 * i);
            py[i]    = Y_W'(20 + 5 * i);
            mx[i]    = '0;
            my[i]    = '0;
            mcol[i]  = '0;
        end
        clear_counts();

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);

        // single slot: erase, advance, redraw
        bus.slot_en     = 7'b0000001;
        bus.slot_colour = 21'b111;
        clear_counts();
        tick();
        wait_fd("single_fd", 1, 200);
        repeat (2) @(negedge clk);
        check("single_plots", n_plot, 26);
        check("single_adv", n_adv[0], 1);
        check("single_starts", n_start[0], 2);
        check("single_sb", sb.size(), 0);
        check("single_busy", bus.busy, 1'b0);

        // skip slots; slot_en change mid-frame must be ignored
        bus.slot_en     = 7'b1000100;
        bus.slot_colour = {3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        clear_counts();
        tick();
        repeat (4) @(negedge clk);
        bus.slot_en = 7'b1111111;
        wait_fd("skip_fd", 1, 400);
        repeat (2) @(negedge clk);
        check("skip_start_mask", start_mask(), 7'b1000100);
        check("skip_adv_mask", adv_mask(), 7'b1000100);
        check("skip_plots", n_plot, 52);
        check("skip_sb", sb.size(), 0);

        // empty frame latency
        bus.slot_en = '0;
        clear_counts();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            bus.frame_tick = 1'b0;
            n++;
            if (bus.frame_done) break;
        end
        check("empty_latency", n, 9);
        repeat (3) @(negedge clk);
        check("empty_plots", n_plot, 0);
        check("empty_starts", start_mask(), 7'b0);

        // isolation: slot 3 chatters while slot 1 is granted
        bus.slot_en = 7'b0000010;
        rogue[3]    = 1'b1;
        clear_counts();
        tick();
        wait_fd("iso_fd", 1, 200);
        repeat (2) @(negedge clk);
        rogue[3] = 1'b0;
        check("iso_plots", n_plot, 26);
        check("iso_sb", sb.size(), 0);
        check("iso_start_mask", start_mask(), 7'b0000010);

        // overrun: pending frame runs back to back, then sticky overrun
        bus.slot_en = 7'b0000001;
        clear_counts();
        tick();
        repeat (5) @(negedge clk);
        tick();
        check("ovr_pending", bus.overrun, 1'b0);
        repeat (3) @(negedge clk);
        tick();
        check("ovr_set", bus.overrun, 1'b1);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.frame_done) break;
        end
        check("ovr_fd1", bus.frame_done, 1'b1);
        @(posedge clk);
        #1;
        check("ovr_gap_idle", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        check("ovr_restart", bus.busy, 1'b1);
        wait_fd("ovr_fd2", 2, 200);
        repeat (100) @(negedge clk);
        check("ovr_frames", n_fd, 2);
        check("ovr_sticky", bus.overrun, 1'b1);
        check("ovr_plots", n_plot, 52);

        // timeout: drawer never reports done
        hang[0] = 1'b1;
        clear_counts();
        tick();
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (bus.spr_start[0]) break;
        end
        check("to_start", bus.spr_start[0], 1'b1);
        check("to_clear", bus.timeout_err, 1'b0);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.spr_advance[0]) break;
        end
        check("to_latency", n, 64);
        check("to_flag", bus.timeout_err, 1'b1);
        wait_fd("to_fd", 1, 300);
        hang[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("to_draw_start", n_start[0], 2);
        check("to_plots", n_plot, 26);

        // reset mid DRAW_WAIT on slot 2
        bus.slot_en = 7'b0000100;
        npix[2]     = 40;
        clear_counts();
        tick();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.spr_advance[2]) break;
        end
        check("rst_adv_seen", bus.spr_advance[2], 1'b1);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        clear_counts();
        repeat (20) @(negedge clk);
        check("rst_no_start", start_mask(), 7'b0);
        check("rst_no_plot", n_plot, 0);
        tick();
        wait_fd("rst_fd", 1, 400);
        repeat (2) @(negedge clk);
        check("rst_plots", n_plot, 80);
        check("rst_sb", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule
